// File: rtl/axis_out_arb.sv
// axis_out_arb: round-robin packet arbiter merging N_SRC AXI-Stream sources onto one output.
//
// A source is granted in IDLE (round-robin starting after the last grant) and keeps the
// grant until its TLAST beat is accepted. The arbiter then returns to IDLE, which costs
// one bubble cycle per packet. Accepted beats pass through a 2-entry skid buffer
// (output register plus one skid slot), so all M_AXIS_* outputs come straight from flops.
//
// Ports:
//   clk, rst                    sole clock, synchronous active-high reset
//   S_AXIS_TDATA/TKEEP/TLAST/   packed per-source slave streams; source i occupies
//   TVALID/TREADY               [i*DATA_W +: DATA_W] and [i*KEEP_W +: KEEP_W]
//   M_AXIS_TDATA/TKEEP/TLAST/   merged master stream
//   TVALID/TREADY
//   grant_idx                   source currently or most recently granted
//   busy                        high while a packet holds the lock
//   pkt_cnt                     per-source completed-packet counters, 16 bits each
//
// Optional feature: define AXIS_ARB_PKT_CNT_EN to build the packet counters. Without it
// pkt_cnt is tied to zero and no counter flops exist.

module axis_out_arb #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_SRC*DATA_W-1:0]           S_AXIS_TDATA,
  input  logic [N_SRC*(DATA_W/8)-1:0]       S_AXIS_TKEEP,
  input  logic [N_SRC-1:0]                  S_AXIS_TLAST,
  input  logic [N_SRC-1:0]                  S_AXIS_TVALID,
  output logic [N_SRC-1:0]                  S_AXIS_TREADY,
  output logic [DATA_W-1:0]                 M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]               M_AXIS_TKEEP,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic [$clog2(N_SRC)-1:0]          grant_idx,
  output logic                              busy,
  output logic [N_SRC*16-1:0]               pkt_cnt
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(N_SRC);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_pick;

  // Skid buffer: out_* is the registered output stage, sk_* the overflow slot.
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [KEEP_W-1:0]  out_keep_q, out_keep_d;
  logic               out_last_q, out_last_d;
  logic               sk_valid_q, sk_valid_d;
  logic [DATA_W-1:0]  sk_data_q, sk_data_d;
  logic [KEEP_W-1:0]  sk_keep_q, sk_keep_d;
  logic               sk_last_q, sk_last_d;

  logic [DATA_W-1:0]  in_data;
  logic [KEEP_W-1:0]  in_keep;
  logic               in_last;
  logic               in_valid;
  logic               accept;
  logic               emit;

  // Granted source's beat.
  assign in_data  = S_AXIS_TDATA[grant_q*DATA_W +: DATA_W];
  assign in_keep  = S_AXIS_TKEEP[grant_q*KEEP_W +: KEEP_W];
  assign in_last  = S_AXIS_TLAST[grant_q];
  assign in_valid = S_AXIS_TVALID[grant_q];

  // Ready only depends on the skid slot, never on M_AXIS_TREADY, so there is no
  // combinational path from the downstream ready to any upstream ready.
  assign accept = (state_q == StBusy) && in_valid && !sk_valid_q;
  assign emit   = out_valid_q && M_AXIS_TREADY;

  always_comb begin
    S_AXIS_TREADY = '0;
    if (state_q == StBusy && !sk_valid_q) begin
      S_AXIS_TREADY[grant_q] = 1'b1;
    end
  end

  // Round-robin search starting one past the last grant.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    rr_pick = grant_q;
    found   = 1'b0;
    cand    = grant_q;
    for (int k = 1; k <= int'(N_SRC); k++) begin
      cand = IDX_W'((int'(grant_q) + k) % int'(N_SRC));
      if (!found && S_AXIS_TVALID[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (|S_AXIS_TVALID) begin
          grant_d = rr_pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (accept && in_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    sk_valid_d  = sk_valid_q;
    sk_data_d   = sk_data_q;
    sk_keep_d   = sk_keep_q;
    sk_last_d   = sk_last_q;
    if (!out_valid_q || emit) begin
      // Output stage frees up: refill from the skid slot first to keep ordering.
      if (sk_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = sk_data_q;
        out_keep_d  = sk_keep_q;
        out_last_d  = sk_last_q;
        sk_valid_d  = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_keep_d  = in_keep;
        out_last_d  = in_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_data_d  = in_data;
      sk_keep_d  = in_keep;
      sk_last_d  = in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= IDX_W'(N_SRC - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_keep_q   <= '0;
      sk_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      sk_valid_q  <= sk_valid_d;
      sk_data_q   <= sk_data_d;
      sk_keep_q   <= sk_keep_d;
      sk_last_q   <= sk_last_d;
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [N_SRC*16-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && in_last) begin
      cnt_d[grant_q*16 +: 16] = cnt_q[grant_q*16 +: 16] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cnt = cnt_q;
`else
  assign pkt_cnt = '0;
`endif

  assign M_AXIS_TVALID = out_valid_q;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TKEEP  = out_keep_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q == StBusy);

endmodule
